// File: rtl/spi_regbank_rw.sv
// -----------------------------------------------------------------------------
// spi_regbank_rw
//   SPI slave (mode 0, MSB first) with an integrated register bank, fully in
//   the CLK domain. CSX/SCLK/SDI are oversampled; a frame is
//   {RW, ADDR[ADDR_W], DATA[DATA_W]}. Writes commit only when CSX rises after
//   exactly FRAME_BITS bits; reads stream reg[addr] on SDO during the data
//   phase. Malformed frames pulse FRAME_ERR and leave the bank untouched.
//
// Ports
//   CLK, RSTX        system clock, async active-low reset
//   CSX, SCLK, SDI   SPI pins (asynchronous to CLK)
//   SDO, SDO_OE      read data out and pad output enable
//   WEN/WADDR/WDATA  one-cycle write strobe, last written address/data
//   FRAME_ERR        one-cycle pulse on a discarded frame
//   REGS             flat register bus, reg k at [k*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module spi_regbank_rw #(
   parameter int               ADDR_W  = 8,
   parameter int               DATA_W  = 8,
   parameter int               NREG    = 4,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic                   CLK,
   input  logic                   RSTX,
   input  logic                   CSX,
   input  logic                   SCLK,
   input  logic                   SDI,
   output logic                   SDO,
   output logic                   SDO_OE,
   output logic                   WEN,
   output logic [ADDR_W-1:0]      WADDR,
   output logic [DATA_W-1:0]      WDATA,
   output logic                   FRAME_ERR,
   output logic [NREG*DATA_W-1:0] REGS
);

   localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
   localparam int CMD_BITS   = 1 + ADDR_W;
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);
   localparam int STAGES     = 2;

   localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(CMD_BITS);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(FRAME_BITS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_OVER = 2'd3;

   // [0],[1] synchroniser, [2] delay flop for edge detection
   logic [STAGES:0] cs_s, sck_s;
   logic [1:0]      sdi_s;
   // vld_pipe[k] is set once stage k holds a real pin sample since reset
   logic [STAGES:0] vld_pipe;

   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         cs_s     <= '1;
         sck_s    <= '0;
         sdi_s    <= '0;
         vld_pipe <= '0;
      end else begin
         cs_s     <= {cs_s[STAGES-1:0], CSX};
         sck_s    <= {sck_s[STAGES-1:0], SCLK};
         sdi_s    <= {sdi_s[0], SDI};
         vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      end
   end

   // A falling CSX only counts once the delay flop holds a real sample, so a
   // frame already running when reset is released is never picked up.
   logic cs_fall, cs_rise, sck_rise, sck_fall;
   assign cs_fall  = vld_pipe[STAGES] & cs_s[2] & ~cs_s[1];
   assign cs_rise  = ~cs_s[2] & cs_s[1];
   assign sck_rise = ~sck_s[2] & sck_s[1];
   assign sck_fall = sck_s[2] & ~sck_s[1];

   logic                        in_frame;
   logic [CNT_W-1:0]            cnt;
   logic [FRAME_BITS-1:0]       sr;
   logic [DATA_W-1:0]           osr;
   logic                        sdo_oe;
   logic [NREG-1:0][DATA_W-1:0] regs;
   logic [1:0]                  state;

   always_comb begin
      state = ST_IDLE;
      if (in_frame) begin
         if (cnt < CNT_CMD)       state = ST_CMD;
         else if (cnt <= CNT_END) state = ST_DATA;
         else                     state = ST_OVER;
      end
   end

   // Fields of a complete frame, valid when cnt == FRAME_BITS
   logic              rw_f;
   logic [ADDR_W-1:0] addr_f;
   logic [DATA_W-1:0] data_f;
   logic              addr_ok;
   assign rw_f    = sr[FRAME_BITS-1];
   assign addr_f  = sr[DATA_W +: ADDR_W];
   assign data_f  = sr[DATA_W-1:0];
   assign addr_ok = int'(addr_f) < NREG;

   // Read mux on the address just shifted in (cnt == CMD_BITS); unimplemented
   // addresses read as zero.
   logic [DATA_W-1:0] rd_val;
   always_comb begin
      rd_val = '0;
      for (int k = 0; k < NREG; k++)
         if (int'(sr[ADDR_W-1:0]) == k) rd_val = regs[k];
   end

   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         in_frame  <= 1'b0;
         cnt       <= '0;
         sr        <= '0;
         osr       <= '0;
         sdo_oe    <= 1'b0;
         WEN       <= 1'b0;
         FRAME_ERR <= 1'b0;
         WADDR     <= '0;
         WDATA     <= '0;
         regs      <= {NREG{RST_VAL}};
      end else begin
         WEN       <= 1'b0;
         FRAME_ERR <= 1'b0;
         if (cs_fall) begin
            in_frame <= 1'b1;
            cnt      <= '0;
            sdo_oe   <= 1'b0;
         end else if (cs_rise) begin
            in_frame <= 1'b0;
            cnt      <= '0;
            sdo_oe   <= 1'b0;
            if (in_frame) begin
               if (cnt != CNT_END) begin
                  FRAME_ERR <= 1'b1;
               end else if (!rw_f) begin
                  if (addr_ok) begin
                     for (int k = 0; k < NREG; k++)
                        if (int'(addr_f) == k) regs[k] <= data_f;
                     WEN   <= 1'b1;
                     WADDR <= addr_f;
                     WDATA <= data_f;
                  end else begin
                     FRAME_ERR <= 1'b1;
                  end
               end
            end
         end else if (in_frame) begin
            if (sck_rise && state != ST_OVER) begin
               sr  <= {sr[FRAME_BITS-2:0], sdi_s[1]};
               cnt <= cnt + CNT_W'(1);
               // this bit pushes the frame into OVER: release the pad
               if (cnt == CNT_END) sdo_oe <= 1'b0;
            end else if (sck_fall) begin
               if (cnt == CNT_CMD && sr[ADDR_W]) begin
                  osr    <= rd_val;
                  sdo_oe <= 1'b1;
               end else if (sdo_oe && cnt > CNT_CMD && cnt < CNT_END) begin
                  osr <= osr << 1;
               end
            end
         end
      end
   end

   assign SDO    = sdo_oe & osr[DATA_W-1];
   assign SDO_OE = sdo_oe;
   assign REGS   = regs;

endmodule

// File: tb/tb_spi_regbank_rw.sv
// -----------------------------------------------------------------------------
// tb_spi_regbank_rw
//   Bench for spi_regbank_rw (ADDR_W=8, DATA_W=8, NREG=4). A bit-banged SPI
//   master drives frames; expected WEN/FRAME_ERR events are queued when a frame
//   is launched and popped by a monitor when the DUT raises a strobe. Read data
//   and SDO_OE are captured at the master's SCLK rising edges.
// -----------------------------------------------------------------------------
module tb_spi_regbank_rw;

   localparam int HALF = 6;   // CLKs per SCLK phase
   localparam int GAP  = 4;   // CLKs of CSX high between frames

   logic        CLK = 1'b0;
   logic        RSTX, CSX, SCLK, SDI;
   logic        SDO, SDO_OE, WEN, FRAME_ERR;
   logic [7:0]  WADDR, WDATA;
   logic [31:0] REGS;

   spi_regbank_rw #(.ADDR_W(8), .DATA_W(8), .NREG(4), .RST_VAL(8'h00)) dut (
      .CLK(CLK), .RSTX(RSTX), .CSX(CSX), .SCLK(SCLK), .SDI(SDI),
      .SDO(SDO), .SDO_OE(SDO_OE), .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA),
      .FRAME_ERR(FRAME_ERR), .REGS(REGS)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [1:0] kind;   // 1 = write strobe, 2 = frame error
      logic [7:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t            exp_q[$];
   ev_t            mon_got, mon_exp;
   logic [3:0][7:0] mregs;
   int             n_chk = 0;
   int             n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, want);
   endtask

   // event monitor: every strobe must match the oldest expectation
   always @(posedge CLK) begin
      #1;
      if (WEN || FRAME_ERR) begin
         mon_got.kind = {FRAME_ERR, WEN};
         mon_got.addr = WEN ? WADDR : 8'h00;
         mon_got.data = WEN ? WDATA : 8'h00;
         if (exp_q.size() == 0) begin
            chk("unexpected_event", 32'(mon_got), 32'h0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("event", 32'(mon_got), 32'(mon_exp));
         end
      end
   end

   // One SPI frame of nbits, MSB of word[nbits-1:0] first. rst_bit >= 0 pulses
   // RSTX while that bit is on the wire. sdo/oe hold one sample per bit.
   task automatic xfer(input int nbits, input logic [31:0] word, input int rst_bit,
                       output logic [31:0] sdo, output logic [31:0] oe);
      sdo = '0;
      oe  = '0;
      CSX = 1'b0;
      repeat (HALF) @(negedge CLK);
      for (int i = 0; i < nbits; i++) begin
         SDI = word[nbits-1-i];
         if (i == rst_bit) begin
            RSTX = 1'b0;
            repeat (2) @(negedge CLK);
            RSTX = 1'b1;
         end
         repeat (HALF) @(negedge CLK);
         sdo  = {sdo[30:0], SDO};
         oe   = {oe[30:0], SDO_OE};
         SCLK = 1'b1;
         repeat (HALF) @(negedge CLK);
         SCLK = 1'b0;
      end
      repeat (HALF) @(negedge CLK);
      CSX = 1'b1;
      SDI = 1'b0;
      repeat (GAP) @(negedge CLK);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input string tag);
      logic [31:0] sb, ob;
      exp_q.push_back({2'd1, a, d});
      mregs[a[1:0]] = d;
      xfer(17, {15'b0, 1'b0, a, d}, -1, sb, ob);
      chk({tag, "_regs"}, REGS, mregs);
      chk({tag, "_oe"}, ob, 32'h0);
   endtask

   task automatic do_read(input logic [7:0] a, input logic [7:0] want, input string tag);
      logic [31:0] sb, ob;
      xfer(17, {15'b0, 1'b1, a, 8'h00}, -1, sb, ob);
      chk({tag, "_data"}, {24'h0, sb[7:0]}, {24'h0, want});
      chk({tag, "_oe"}, ob, 32'h0000_00FF);
      chk({tag, "_regs"}, REGS, mregs);
   endtask

   task automatic do_bad(input int nbits, input logic [31:0] word, input string tag);
      logic [31:0] sb, ob;
      exp_q.push_back({2'd2, 8'h00, 8'h00});
      xfer(nbits, word, -1, sb, ob);
      chk({tag, "_regs"}, REGS, mregs);
   endtask

   initial begin
      logic [31:0] sb, ob;
      RSTX  = 1'b0;
      CSX   = 1'b1;
      SCLK  = 1'b0;
      SDI   = 1'b0;
      mregs = '0;
      repeat (3) @(negedge CLK);
      chk("rst_regs", REGS, 32'h0);
      chk("rst_sdo", {30'h0, SDO_OE, SDO}, 32'h0);
      chk("rst_strobes", {30'h0, WEN, FRAME_ERR}, 32'h0);
      chk("rst_wbus", {16'h0, WADDR, WDATA}, 32'h0);
      RSTX = 1'b1;
      repeat (4) @(negedge CLK);

      // write then read back
      do_write(8'h02, 8'hA5, "wr2");
      chk("wr2_bus", REGS, 32'h00A5_0000);
      do_read(8'h02, 8'hA5, "rd2");

      // short (12-bit) and over-length (18-bit) writes to addr 1
      do_bad(12, {20'h0, 1'b0, 8'h01, 3'b101}, "short");
      do_bad(18, {14'h0, 1'b0, 8'h01, 8'h5A, 1'b1}, "long");
      chk("hold_wbus", {16'h0, WADDR, WDATA}, 32'h0000_02A5);

      // unimplemented address: write errors, read returns zero
      do_bad(17, {15'h0, 1'b0, 8'h07, 8'hFF}, "wr7");
      do_read(8'h07, 8'h00, "rd7");

      // reset during data bit 3 of a write to addr 0
      xfer(17, {15'h0, 1'b0, 8'h00, 8'h3C}, 12, sb, ob);
      mregs = '0;
      chk("midrst_regs", REGS, 32'h0);
      chk("midrst_wbus", {16'h0, WADDR, WDATA}, 32'h0);

      // back-to-back writes after the reset
      do_write(8'h00, 8'h11, "b2b0");
      do_write(8'h03, 8'h33, "b2b1");
      chk("b2b_bus", REGS, 32'h3300_0011);
      do_read(8'h03, 8'h33, "rd3");

      repeat (20) @(negedge CLK);
      chk("events_left", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
